// File: rtl/ic_if.sv
// Pin-level interface between a 3-input gate tester (master) and the device it exercises (slave).
// Fault-injection pins exist only when FAULT_INJECT_EN is defined.
interface ic_if;
   logic       A1, B1, C1;
   logic       A2, B2, C2;
   logic       A3, B3, C3;
   logic [2:0] gateSelect;
   logic       op1, op2, op3;
   logic [2:0] busy;
`ifdef FAULT_INJECT_EN
   logic [2:0] fault_en;
   logic [2:0] fault_val;
`endif

   modport master (
      output A1, B1, C1, A2, B2, C2, A3, B3, C3, gateSelect,
`ifdef FAULT_INJECT_EN
      output fault_en, fault_val,
`endif
      input  op1, op2, op3, busy
   );

   modport slave (
      input  A1, B1, C1, A2, B2, C2, A3, B3, C3, gateSelect,
`ifdef FAULT_INJECT_EN
      input  fault_en, fault_val,
`endif
      output op1, op2, op3, busy
   );
endinterface

// File: rtl/three_input_ic_emulator.sv
// Emulates three 3-input gates with an inertial propagation delay per channel, standing in for a real IC.
// Optional stuck-at fault injection is enabled by defining FAULT_INJECT_EN.
module three_input_ic_emulator #(
   parameter int PROP_DELAY = 4,
   parameter int CNT_W      = 8
) (
   input logic clk,
   input logic reset,
   ic_if.slave pins
);

   typedef enum logic {IDLE, PENDING} ch_state_e;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PROP_DELAY - 1);

   logic [2:0]       in_q [3];
   logic [2:0]       sel_q;
   logic [2:0]       target;
   ch_state_e        state_q [3];
   ch_state_e        state_d [3];
   logic [CNT_W-1:0] cnt_q [3];
   logic [CNT_W-1:0] cnt_d [3];
   logic [2:0]       op_q, op_d;
   logic [2:0]       busy_q;

   function automatic logic gate_fn(input logic [2:0] sel, input logic [2:0] p);
      case (sel)
         3'b000:  return &p;
         3'b001:  return |p;
         3'b010:  return ~&p;
         3'b011:  return ~|p;
         3'b100:  return ^p;
         3'b101:  return ~^p;
         default: return 1'b0;
      endcase
   endfunction

   // NOTE: the input stage has no reset on purpose: it keeps sampling the pins during reset so the
   // first target after release already reflects the pins, giving the normal latency from release.
   always_ff @(posedge clk) begin
      in_q[0] <= {pins.C1, pins.B1, pins.A1};
      in_q[1] <= {pins.C2, pins.B2, pins.A2};
      in_q[2] <= {pins.C3, pins.B3, pins.A3};
      sel_q   <= pins.gateSelect;
   end

   always_comb begin
      for (int n = 0; n < 3; n++) target[n] = gate_fn(sel_q, in_q[n]);
   end

   // State register; busy is registered from the next state so it always matches state_q.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int n = 0; n < 3; n++) begin
            state_q[n] <= IDLE;
            cnt_q[n]   <= '0;
         end
         op_q   <= '0;
         busy_q <= '0;
      end else begin
         for (int n = 0; n < 3; n++) begin
            state_q[n] <= state_d[n];
            cnt_q[n]   <= cnt_d[n];
            busy_q[n]  <= (state_d[n] == PENDING);
         end
         op_q <= op_d;
      end
   end

   // NOTE: every combinational output gets a default before the case so no latch is inferred.
   always_comb begin
      for (int n = 0; n < 3; n++) begin
         state_d[n] = state_q[n];
         case (state_q[n])
            IDLE:    if (target[n] != op_q[n]) state_d[n] = PENDING;
            PENDING: if (target[n] == op_q[n] || cnt_q[n] == '0) state_d[n] = IDLE;
            default: state_d[n] = IDLE;
         endcase
`ifdef FAULT_INJECT_EN
         if (pins.fault_en[n]) state_d[n] = IDLE;
`endif
      end
   end

   // Output/datapath decode: counter load and decrement, and the delayed op update.
   always_comb begin
      op_d = op_q;
      for (int n = 0; n < 3; n++) begin
         cnt_d[n] = cnt_q[n];
         case (state_q[n])
            IDLE:    if (target[n] != op_q[n]) cnt_d[n] = CNT_LOAD;
            PENDING: begin
               if (target[n] != op_q[n]) begin
                  if (cnt_q[n] == '0) op_d[n] = target[n];
                  else                cnt_d[n] = cnt_q[n] - 1'b1;
               end
            end
            default: cnt_d[n] = '0;
         endcase
`ifdef FAULT_INJECT_EN
         if (pins.fault_en[n]) op_d[n] = pins.fault_val[n];
`endif
      end
   end

   assign pins.op1 = op_q[0];
   assign pins.op2 = op_q[1];
   assign pins.op3 = op_q[2];
   assign pins.busy = busy_q;

endmodule

// File: tb/tb_three_input_ic_emulator.sv
// Scoreboard bench for three_input_ic_emulator: directed scenarios followed by random pin/select/reset traffic.
// Fault-injection scenarios are included when FAULT_INJECT_EN is defined.
module tb_three_input_ic_emulator;
   localparam int PD = 4;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic [5:0] sb[$];
   logic [2:0] pat[3];
   logic [2:0] sel;

   always #5 clk = ~clk;

   ic_if pins();

   three_input_ic_emulator #(.PROP_DELAY(PD), .CNT_W(8)) dut (
      .clk  (clk),
      .reset(reset),
      .pins (pins)
   );

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] op_now();
      return {pins.op3, pins.op2, pins.op1};
   endfunction

   task automatic drive(input logic [2:0] g1, input logic [2:0] g2, input logic [2:0] g3,
                        input logic [2:0] s);
      pins.A1 = g1[0]; pins.B1 = g1[1]; pins.C1 = g1[2];
      pins.A2 = g2[0]; pins.B2 = g2[1]; pins.C2 = g2[2];
      pins.A3 = g3[0]; pins.B3 = g3[1]; pins.C3 = g3[2];
      pins.gateSelect = s;
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference gate from the function table, by counting ones.
   function automatic logic ref_gate(input logic [2:0] s, input logic [2:0] p);
      int ones = $countones(p);
      case (s)
         3'd0:    return ones == 3;
         3'd1:    return ones > 0;
         3'd2:    return ones != 3;
         3'd3:    return ones == 0;
         3'd4:    return (ones % 2) == 1;
         3'd5:    return (ones % 2) == 0;
         default: return 1'b0;
      endcase
   endfunction

   // Inertial delay model: output follows the target once it has disagreed on PD+1 consecutive edges.
   logic [2:0] m_in[3];
   logic [2:0] m_sel;
   logic [2:0] m_op;
   int         run[3];

   always @(posedge clk) begin
      logic [2:0] busy_e;
      logic       t;
      busy_e = '0;
      for (int n = 0; n < 3; n++) begin
         if (reset) begin
            m_op[n] = 1'b0;
            run[n]  = 0;
         end else begin
            t = ref_gate(m_sel, m_in[n]);
`ifdef FAULT_INJECT_EN
            if (pins.fault_en[n]) begin
               m_op[n] = pins.fault_val[n];
               run[n]  = 0;
            end else
`endif
            if (t == m_op[n]) run[n] = 0;
            else begin
               run[n]++;
               if (run[n] == PD + 1) begin
                  m_op[n] = t;
                  run[n]  = 0;
               end
            end
         end
         busy_e[n] = (run[n] != 0);
      end
      m_in[0] = {pins.C1, pins.B1, pins.A1};
      m_in[1] = {pins.C2, pins.B2, pins.A2};
      m_in[2] = {pins.C3, pins.B3, pins.A3};
      m_sel   = pins.gateSelect;
      sb.push_back({busy_e, m_op});
   end

   always @(negedge clk) begin
      logic [5:0] e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("sb_op", {3'b000, op_now()}, {3'b000, e[2:0]});
         check("sb_busy", {3'b000, pins.busy}, {3'b000, e[5:3]});
      end
   end

   initial begin
      reset = 1'b1;
`ifdef FAULT_INJECT_EN
      pins.fault_en  = '0;
      pins.fault_val = '0;
`endif
      drive(3'b000, 3'b000, 3'b000, 3'b010);
      repeat (3) begin
         @(posedge clk); #1;
         check("reset_op", {3'b000, op_now()}, 6'b000000);
      end
      reset = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk); #1;
         check("nand_op", {3'b000, op_now()}, (i == 5) ? 6'b000111 : 6'b000000);
         check("nand_busy", {3'b000, pins.busy}, (i < 5) ? 6'b000111 : 6'b000000);
      end

      // AND, gate 1 pins 011 -> 111
      drive(3'b011, 3'b000, 3'b000, 3'b000);
      settle(8);
      drive(3'b111, 3'b000, 3'b000, 3'b000);
      for (int i = 0; i <= 5; i++) begin
         @(posedge clk); #1;
         check("and_op", {3'b000, op_now()}, (i == 5) ? 6'b000001 : 6'b000000);
         check("and_busy", {3'b000, pins.busy}, (i >= 1 && i <= 4) ? 6'b000001 : 6'b000000);
      end

      // Two-cycle glitch on gate 1 is filtered
      drive(3'b011, 3'b000, 3'b000, 3'b000);
      settle(8);
      drive(3'b111, 3'b000, 3'b000, 3'b000);
      for (int i = 0; i <= 7; i++) begin
         @(posedge clk); #1;
         check("glitch_op", {3'b000, op_now()}, 6'b000000);
         check("glitch_busy", {3'b000, pins.busy}, (i == 1 || i == 2) ? 6'b000001 : 6'b000000);
         if (i == 1) drive(3'b011, 3'b000, 3'b000, 3'b000);
      end

      // Select change OR -> NOR with all pins low
      drive(3'b000, 3'b000, 3'b000, 3'b001);
      settle(8);
      drive(3'b000, 3'b000, 3'b000, 3'b011);
      for (int i = 0; i <= 5; i++) begin
         @(posedge clk); #1;
         check("sel_op", {3'b000, op_now()}, (i == 5) ? 6'b000111 : 6'b000000);
      end
      drive(3'b000, 3'b000, 3'b000, 3'b001);
      settle(8);
      drive(3'b000, 3'b000, 3'b000, 3'b011);
      for (int i = 0; i <= 7; i++) begin
         @(posedge clk); #1;
         check("sel_cancel_op", {3'b000, op_now()}, 6'b000000);
         if (i == 1) drive(3'b000, 3'b000, 3'b000, 3'b001);
      end

      // Reset two cycles into PENDING
      settle(6);
      drive(3'b000, 3'b000, 3'b000, 3'b011);
      for (int i = 0; i <= 8; i++) begin
         @(posedge clk); #1;
         check("pend_rst_op", {3'b000, op_now()}, (i == 8) ? 6'b000111 : 6'b000000);
         check("pend_rst_busy", {3'b000, pins.busy},
               ((i >= 1 && i <= 2) || (i >= 4 && i <= 7)) ? 6'b000111 : 6'b000000);
         if (i == 2) reset = 1'b1;
         if (i == 3) reset = 1'b0;
      end

`ifdef FAULT_INJECT_EN
      drive(3'b111, 3'b111, 3'b111, 3'b000);
      settle(8);
      pins.fault_en  = 3'b010;
      pins.fault_val = 3'b000;
      @(posedge clk); #1;
      check("fault_op", {3'b000, op_now()}, 6'b000101);
      pins.fault_en = 3'b000;
      for (int j = 1; j <= 5; j++) begin
         @(posedge clk); #1;
         check("fault_rel_op", {3'b000, op_now()}, (j == 5) ? 6'b000111 : 6'b000101);
      end
`endif

      // Random traffic checked by the scoreboard
      pat[0] = 3'b000; pat[1] = 3'b000; pat[2] = 3'b000; sel = 3'b000;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         for (int g = 0; g < 3; g++)
            if ($urandom_range(5) == 0) pat[g] = 3'($urandom_range(7));
         if ($urandom_range(24) == 0) sel = 3'($urandom_range(7));
         reset = ($urandom_range(199) == 0);
`ifdef FAULT_INJECT_EN
         if ($urandom_range(39) == 0) begin
            pins.fault_en  = 3'($urandom_range(7));
            pins.fault_val = 3'($urandom_range(7));
         end else if ($urandom_range(7) == 0) begin
            pins.fault_en = '0;
         end
`endif
         drive(pat[0], pat[1], pat[2], sel);
      end

      reset = 1'b0;
      settle(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
